// File: rtl/da_fir_serial_ctrl.sv
// Bit-serial DA sequencer for a 10-tap symmetric FIR; result pulses 15 cycles after accept.
// One sample in flight at a time: in_ready drops on accept and returns once the result is out.
module da_fir_serial_ctrl #(
  parameter int DW    = 12,
  parameter int LUT_W = 18,
  parameter int OUT_W = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_data,
  output logic [4:0]              lut_addr,
  input  logic signed [LUT_W-1:0] lut_data,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    busy
);

  localparam int KW = $clog2(DW + 1);
  localparam logic [KW-1:0] KMAX = KW'(DW);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic signed [DW-1:0]  d [0:9];
  logic signed [DW:0]    p [0:4];
  logic signed [OUT_W:0] acc, acc_nxt, lut_ext, term;
  logic [KW-1:0]         k;
  logic                  accept;
  logic                  last_bit;

  assign accept   = in_valid & in_ready & (state == IDLE);
  assign last_bit = (state == RUN) && (k == KMAX);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN:  if (k == KMAX) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address bit i carries bit k of pre-add sum i; parked at 0 outside RUN.
  always_comb begin
    lut_addr = '0;
    if (state == RUN) begin
      for (int i = 0; i < 5; i++) lut_addr[i] = p[i][k];
    end
  end

  // Bit DW of the pre-add sums is the sign bit and carries negative weight.
  always_comb begin
    lut_ext = {{(OUT_W + 1 - LUT_W){lut_data[LUT_W-1]}}, lut_data};
    term    = lut_ext <<< k;
    acc_nxt = (k == KMAX) ? acc - term : acc + term;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) d[i] <= '0;
      for (int i = 0; i < 5; i++)  p[i] <= '0;
      acc       <= '0;
      k         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= last_bit;
      if (accept) begin
        d[0] <= in_data;
        for (int i = 1; i < 10; i++) d[i] <= d[i-1];
      end
      if (state == LOAD) begin
        for (int i = 0; i < 5; i++)
          p[i] <= {d[i][DW-1], d[i]} + {d[9-i][DW-1], d[9-i]};
        acc <= '0;
        k   <= '0;
      end
      if (state == RUN) begin
        acc <= acc_nxt;
        k   <= k + 1'b1;
      end
      if (last_bit) out_data <= acc_nxt[OUT_W-1:0];
    end
  end

endmodule

// File: doc/da_fir_serial_ctrl.md
Name: da_fir_serial_ctrl

Overview:
Bit-serial distributed-arithmetic sequencer for the 10-tap symmetric FIR (12-bit in, 30-bit out, symmetric coefficients 2020, 6589, 15718, 25602, 32768).
- Accepts one sample per handshake and holds the 10-deep delay line.
- Pre-adds the symmetric tap pairs and walks the pre-added sums bit by bit through an external 32-entry DA LUT.
- Shift-accumulates the LUT words into the filter result.
- Trades throughput for area: one shared LUT, no multipliers, one output per 16 cycles.

Parameters:
DW, 12, input sample width (signed)
LUT_W, 18, LUT word width (signed; max LUT value 82697)
OUT_W, 30, output width (signed)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  sample offered
in_ready  out  1  controller can accept a sample
in_data  in  DW  signed sample
lut_addr  out  5  DA LUT address; bit i = bit k of pre-add sum p_i
lut_data  in  LUT_W  LUT word, combinational read of lut_addr in the same cycle
out_valid  out  1  one-cycle pulse, out_data is a new result
out_data  out  OUT_W  signed filter result, held until next result
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: all of the following clear to 0 immediately on rst and stay 0 while rst is high:
  - delay line d0..d9, pre-add registers p0..p4, accumulator, bit counter
  - out_data, out_valid, in_ready, busy, lut_addr
  - state is IDLE
- in_ready is registered. It goes 1 on the first edge after rst falls.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready at edge E0: shift d0<=in_data, d(i)<=d(i-1), in_ready<=0, go to LOAD.
  - LOAD (1 cycle): register p_i = d_i + d_(9-i), i=0..4, sign-extended to DW+1 bits. Clear accumulator, k=0, go to RUN.
  - RUN (DW+1 = 13 cycles, k=0..12):
    - lut_addr[i] = p_i[k].
    - For k<12: acc += sext(lut_data) << k.
    - For k=12 (sign bit): acc -= sext(lut_data) << 12.
    - After k=12, go to DONE.
  - DONE (1 cycle): out_data <= acc[OUT_W-1:0], out_valid=1, then go to IDLE with in_ready<=1.
- lut_addr is 0 outside RUN.
- Timing: accept at E0; out_valid high in cycle 15 after E0; in_ready high again in cycle 16.
  - Throughput is exactly 1 sample / 16 cycles with in_valid held high.
- Arithmetic: acc is OUT_W+1 bits wide internally.
  - Result equals sum_i coeff_i*(d_i + d_(9-i)) exactly. Range ±338.8M fits 30 bits, so no saturation is needed.
- in_data and in_valid are ignored outside IDLE. The delay line shifts only on an accepted sample.
- out_valid lasts exactly 1 cycle. out_data holds its value between results.
- Reset mid-operation (any state): the current computation is aborted, the delay line is zeroed, and no out_valid is produced. Behaviour after release is identical to after power-up.
- LUT contract: lut_data(a) = sum of coeff_i over every i where a[i]=1; lut_data(0)=0, lut_data(31)=82697. The bench provides the LUT model.

Test Plan:
- Reset then impulse: in_data=1, then 10 samples of 0 → outputs in order 2020, 6589, 15718, 25602, 32768, 32768, 25602, 15718, 6589, 2020, 0. Each out_valid arrives exactly 15 cycles after its accept.
- Negative impulse: in_data=-2048, then zeros → first output -4136960; the tenth output is also -4136960.
- Full-scale: 10 samples of 2047 → tenth output 338561518. 10 samples of -2048 → tenth output -338726912. No wrap in either case.
- Streaming: in_valid held high with random data → accepts exactly every 16 cycles; in_ready=0 for 15 cycles between accepts; every result matches the multiply-accumulate reference model.
- Reset during RUN (k=6): assert rst for 2 cycles → out_valid is never asserted; all outputs read 0. A following impulse reproduces the first scenario exactly, with no stale delay-line data.
- Idle gaps: in_valid low for 40 cycles between samples → out_data holds its last value; out_valid stays 0; lut_addr=0; busy=0.
